alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single combinational `alu` instance between two requesters: requester 0 is the core execute stage and requester 1 is the auxiliary or debug port. Operation requests are accepted with valid/ready, arbitrated round-robin, and issued to the ALU. Operands are held stable for the operation's latency (multi-cycle for MAC). The registered result and tag are returned on a per-requester valid/ready response channel.

## Interface
- `TAG_W`, 4: width of the requester-supplied tag echoed with the result
- `MAC_LAT`, 2: cycles operands are held for `MAC_ALU` before capture; legal range 1–15
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous reset, active-low
- `reqN_valid`  in  1  request valid (N = 0, 1)
- `reqN_ready`  out  1  request accepted when valid & ready
- `reqN_op`  in  4  ALU opcode (`ADD_ALU` … `MAC_ALU`)
- `reqN_rs1`, `reqN_rs2`, `reqN_rs3`  in  32 each  operands
- `reqN_tag`  in  TAG_W  tag
- `respN_valid`  out  1  result valid
- `respN_ready`  in  1  result consumed when valid & ready
- `respN_rd`  out  32  result
- `respN_tag`  out  TAG_W  echoed tag
- `respN_err`  out  1  opcode was not a defined ALU op
- `alu_rs1`, `alu_rs2`, `alu_rs3`  out  32 each  to ALU
- `alu_opcode`  out  4  to ALU
- `alu_reset`  out  1  to ALU active-high reset, `= ~reset`
- `alu_rd`  in  32  from ALU

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - `grant0 = req0_valid & (!req1_valid | last==1)` and `grant1 = req1_valid & (!req0_valid | last==0)`.
  - `reqN_ready = (state==IDLE) & (!reqM_valid | last==M)`, where M is the other requester. Ready never depends on the requester's own valid.
  - On acceptance:
    - latch op, rs1/2/3 and tag into operand registers;
    - set `owner=N`;
    - load `cnt = (op==MAC_ALU) ? MAC_LAT-1 : 0`;
    - set `err` if op is not a defined encoding;
    - go to EXEC.
- **EXEC**
  - `alu_*` are driven from the operand registers and are stable for the whole state.
  - If `cnt!=0`, decrement it.
  - When `cnt==0`, capture result and go to RESP. The result is `alu_rd`, or 32'h0 if `err`.
- **RESP**
  - `resp[owner]_valid=1`, with rd, tag and err from the result registers. The other response valid stays 0.
  - On `resp[owner]_ready`: set `last=owner` and go to IDLE.
  - Back-pressure holds RESP indefinitely with all outputs stable.
- Outside EXEC, `alu_*` hold the last operand-register values; no new operand is driven.
- Only one operation is in flight; no request is accepted outside IDLE.
- An illegal opcode still consumes one EXEC cycle. It returns rd=0 and err=1; the ALU's X output is never registered.

## Timing
- Reset values (asynchronous, while `reset`=0):
  - state=IDLE, `last`=1 (requester 0 wins first tie);
  - cnt=0, operand and result registers 0, err=0;
  - all `respN_valid`=0.
  - `reqN_ready` follows the IDLE equation immediately.
- Latency, counting the acceptance edge as cycle 0:
  - non-MAC: `resp_valid` is high from cycle 2;
  - MAC: `resp_valid` is high from cycle `MAC_LAT+1`.
- Minimum issue interval is 3 cycles for non-MAC ops (IDLE→EXEC→RESP→IDLE with zero-wait response).
- Simultaneous valids alternate strictly. A requester that is alone wins every IDLE.
- A requester may drop valid before it is accepted without penalty. The arbiter takes no action on an unaccepted request.
- Reset asserted mid-EXEC or mid-RESP:
  - the in-flight op is discarded and no response is produced;
  - the FSM is in IDLE on the first clock after release.
- `respN_rd`, `respN_tag` and `respN_err` are registered outputs. `reqN_ready` is combinational from state, `last` and the other requester's valid.

## Structure
- Opcode encodings (`ADD_ALU`, `SUB_ALU`, `AND_ALU`, `OR_ALU`, `SLL_ALU`, `SRA_ALU`, `MAC_ALU`) come from the shared `riscv_define_all.v`.
- Add to the same shared header:
  - FSM state encodings `ARB_IDLE`, `ARB_EXEC`, `ARB_RESP`;
  - an `IS_LEGAL_ALU_OP` macro.
- One sub-module is natural: `alu_rr_pick`, a 2-way round-robin grant from two valids plus `last`. The `alu` itself is instantiated by the parent, not inside this block.

## Test plan
- **Single ADD:** req0 ADD rs1=5 rs2=7 tag=3, resp0_ready=1 → resp0_valid at cycle 2 with rd=12, tag=3, err=0. Exactly one pulse.
- **Tie:** both valid every cycle, req0 SUB 10−3, req1 OR 0xF0|0x0F → grants in order 0,1,0,1. Results 7 and 0xFF appear on the matching response ports. `reqN_ready` is never high for both.
- **MAC with MAC_LAT=2:** req1 MAC 3,4,rs3=5 → `alu_*` constant for 2 EXEC cycles, resp1 rd=17 at cycle 3. With MAC_LAT=4, it arrives at cycle 5.
- **Back-pressure:** resp0_ready=0 for 5 cycles after valid → rd, tag and valid held stable. req1 not accepted until 1 cycle after the resp0 handshake.
- **Illegal opcode 4'hF:** → rd=0, err=1 at cycle 2; no X on `respN_rd`.
- **Reset mid-MAC:** assert reset in EXEC cycle 1 → no response. After release, ready is high in IDLE and req0 wins the next tie.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared encodings for the ALU request arbiter: ALU opcodes, arbiter FSM
// states and the legal-opcode check.
package alu_arbiter_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [3:0] {
    ADD_ALU = 4'd0,
    SUB_ALU = 4'd1,
    AND_ALU = 4'd2,
    OR_ALU  = 4'd3,
    SLL_ALU = 4'd4,
    SRA_ALU = 4'd5,
    MAC_ALU = 4'd6
  } alu_op_e;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_EXEC,
    ARB_RESP
  } arb_state_e;

  function automatic logic is_legal_alu_op(input logic [3:0] op);
    logic legal;
    case (op)
      ADD_ALU, SUB_ALU, AND_ALU, OR_ALU, SLL_ALU, SRA_ALU, MAC_ALU: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Two-way round-robin pick: a requester is eligible when the other one is
// idle or was served last; grant is eligibility qualified by its own valid.
module alu_rr_pick (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic last_i,
  output logic elig0_o,
  output logic elig1_o,
  output logic grant0_o,
  output logic grant1_o
);

  // Eligibility deliberately ignores the requester's own valid.
  assign elig0_o  = ~valid1_i | last_i;
  assign elig1_o  = ~valid0_i | ~last_i;
  assign grant0_o = valid0_i & elig0_o;
  assign grant1_o = valid1_i & elig1_o;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between the execute stage (requester 0) and
// the aux/debug port (requester 1), one operation in flight at a time.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned MAC_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [31:0]      req0_rs1,
  input  logic [31:0]      req0_rs2,
  input  logic [31:0]      req0_rs3,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [31:0]      req1_rs1,
  input  logic [31:0]      req1_rs2,
  input  logic [31:0]      req1_rs3,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [31:0]      resp0_rd,
  output logic [TAG_W-1:0] resp0_tag,
  output logic             resp0_err,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [31:0]      resp1_rd,
  output logic [TAG_W-1:0] resp1_tag,
  output logic             resp1_err,
  output logic [31:0]      alu_rs1,
  output logic [31:0]      alu_rs2,
  output logic [31:0]      alu_rs3,
  output logic [3:0]       alu_opcode,
  output logic             alu_reset,
  input  logic [31:0]      alu_rd
);

  localparam logic [3:0] MAC_CNT = 4'(MAC_LAT - 1);

  arb_state_e       state_q, state_d;
  logic             last_q, last_d;
  logic             owner_q, owner_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [31:0]      rs1_q, rs1_d;
  logic [31:0]      rs2_q, rs2_d;
  logic [31:0]      rs3_q, rs3_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             err_q, err_d;
  logic [31:0]      rd_q, rd_d;

  logic elig0, elig1, grant0, grant1;
  logic [3:0] op_sel;
  logic owner_ready;

  alu_rr_pick u_pick (
    .valid0_i (req0_valid),
    .valid1_i (req1_valid),
    .last_i   (last_q),
    .elig0_o  (elig0),
    .elig1_o  (elig1),
    .grant0_o (grant0),
    .grant1_o (grant1)
  );

  assign op_sel      = grant1 ? req1_op : req0_op;
  assign owner_ready = owner_q ? resp1_ready : resp0_ready;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rs3_d   = rs3_q;
    tag_d   = tag_q;
    err_d   = err_q;
    rd_d    = rd_q;
    case (state_q)
      ARB_IDLE: begin
        if (grant0 | grant1) begin
          owner_d = grant1;
          op_d    = op_sel;
          rs1_d   = grant1 ? req1_rs1 : req0_rs1;
          rs2_d   = grant1 ? req1_rs2 : req0_rs2;
          rs3_d   = grant1 ? req1_rs3 : req0_rs3;
          tag_d   = grant1 ? req1_tag : req0_tag;
          cnt_d   = (op_sel == MAC_ALU) ? MAC_CNT : '0;
          err_d   = ~is_legal_alu_op(op_sel);
          state_d = ARB_EXEC;
        end
      end
      ARB_EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Illegal ops never register the ALU output, which may be X.
          rd_d    = err_q ? '0 : alu_rd;
          state_d = ARB_RESP;
        end
      end
      ARB_RESP: begin
        if (owner_ready) begin
          last_d  = owner_q;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      cnt_q   <= '0;
      op_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rs3_q   <= '0;
      tag_q   <= '0;
      err_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rs3_q   <= rs3_d;
      tag_q   <= tag_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
    end
  end

  assign req0_ready  = (state_q == ARB_IDLE) & elig0;
  assign req1_ready  = (state_q == ARB_IDLE) & elig1;

  assign resp0_valid = (state_q == ARB_RESP) & ~owner_q;
  assign resp1_valid = (state_q == ARB_RESP) & owner_q;
  assign resp0_rd    = rd_q;
  assign resp1_rd    = rd_q;
  assign resp0_tag   = tag_q;
  assign resp1_tag   = tag_q;
  assign resp0_err   = err_q;
  assign resp1_err   = err_q;

  assign alu_rs1     = rs1_q;
  assign alu_rs2     = rs2_q;
  assign alu_rs3     = rs3_q;
  assign alu_opcode  = op_q;
  assign alu_reset   = ~reset;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int MAC_LAT = 2;

  logic clk, reset;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_op, req1_op, req0_tag, req1_tag;
  logic [31:0] req0_rs1, req0_rs2, req0_rs3, req1_rs1, req1_rs2, req1_rs3;
  logic resp0_valid, resp0_ready, resp0_err, resp1_valid, resp1_ready, resp1_err;
  logic [31:0] resp0_rd, resp1_rd;
  logic [3:0] resp0_tag, resp1_tag;
  logic [31:0] alu_rs1, alu_rs2, alu_rs3, alu_rd;
  logic [3:0] alu_opcode;
  logic alu_reset;

  // second instance with a longer MAC latency, requester 1 only
  logic x_req0_ready, x_req1_valid, x_req1_ready;
  logic [3:0] x_req1_op, x_resp0_tag, x_resp1_tag, x_alu_opcode;
  logic [31:0] x_req1_rs1, x_req1_rs2, x_req1_rs3;
  logic x_resp0_valid, x_resp0_err, x_resp1_valid, x_resp1_err, x_alu_reset;
  logic [31:0] x_resp0_rd, x_resp1_rd, x_alu_rs1, x_alu_rs2, x_alu_rs3, x_alu_rd;

  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, b, c);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a << b[4:0];
      4'd5: return $unsigned($signed(a) >>> b[4:0]);
      4'd6: return a * b + c;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_rd   = ref_alu(alu_opcode, alu_rs1, alu_rs2, alu_rs3);
  assign x_alu_rd = ref_alu(x_alu_opcode, x_alu_rs1, x_alu_rs2, x_alu_rs3);

  alu_arbiter #(.TAG_W(4), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_rs1(req0_rs1), .req0_rs2(req0_rs2), .req0_rs3(req0_rs3), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_rs1(req1_rs1), .req1_rs2(req1_rs2), .req1_rs3(req1_rs3), .req1_tag(req1_tag),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_rd(resp0_rd),
    .resp0_tag(resp0_tag), .resp0_err(resp0_err),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_rd(resp1_rd),
    .resp1_tag(resp1_tag), .resp1_err(resp1_err),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_rs3(alu_rs3),
    .alu_opcode(alu_opcode), .alu_reset(alu_reset), .alu_rd(alu_rd)
  );

  alu_arbiter #(.TAG_W(4), .MAC_LAT(4)) dut4 (
    .clk(clk), .reset(reset),
    .req0_valid(1'b0), .req0_ready(x_req0_ready), .req0_op(4'd0),
    .req0_rs1(32'd0), .req0_rs2(32'd0), .req0_rs3(32'd0), .req0_tag(4'd0),
    .req1_valid(x_req1_valid), .req1_ready(x_req1_ready), .req1_op(x_req1_op),
    .req1_rs1(x_req1_rs1), .req1_rs2(x_req1_rs2), .req1_rs3(x_req1_rs3), .req1_tag(4'd7),
    .resp0_valid(x_resp0_valid), .resp0_ready(1'b1), .resp0_rd(x_resp0_rd),
    .resp0_tag(x_resp0_tag), .resp0_err(x_resp0_err),
    .resp1_valid(x_resp1_valid), .resp1_ready(1'b1), .resp1_rd(x_resp1_rd),
    .resp1_tag(x_resp1_tag), .resp1_err(x_resp1_err),
    .alu_rs1(x_alu_rs1), .alu_rs2(x_alu_rs2), .alu_rs3(x_alu_rs3),
    .alu_opcode(x_alu_opcode), .alu_reset(x_alu_reset), .alu_rd(x_alu_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: one pending op with the cycle its response becomes due.
  int          cyc = 0;
  bit          m_pend = 1'b0;
  bit          m_owner = 1'b0;
  bit          m_last = 1'b1;
  int          m_due = 0;
  logic [31:0] m_rd = '0;
  logic [3:0]  m_tag = '0;
  bit          m_err = 1'b0;
  bit          a0, a1;
  int          acc_q[$];
  int          acc_cyc[$];

  typedef struct {
    int          port;
    logic [31:0] rd;
    logic [3:0]  tag;
    logic        err;
    int          cyc;
  } rsp_t;
  rsp_t rsp_q[$];

  function automatic bit m_rdy(input int n);
    if (m_pend) return 1'b0;
    return (n == 0) ? (!req1_valid || m_last) : (!req0_valid || !m_last);
  endfunction

  function automatic bit m_ev(input int n);
    return m_pend && (cyc >= m_due) && (int'(m_owner) == n);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pend = 1'b0;
      m_last = 1'b1;
    end else begin
      a0 = req0_valid && m_rdy(0);
      a1 = req1_valid && m_rdy(1);
      if (m_pend && cyc >= m_due && (m_owner ? resp1_ready : resp0_ready)) begin
        m_pend = 1'b0;
        m_last = m_owner;
      end
      cyc++;
      if (a0 || a1) begin
        logic [3:0]  op;
        logic [31:0] x, y, z;
        op = a1 ? req1_op : req0_op;
        x  = a1 ? req1_rs1 : req0_rs1;
        y  = a1 ? req1_rs2 : req0_rs2;
        z  = a1 ? req1_rs3 : req0_rs3;
        m_pend  = 1'b1;
        m_owner = a1;
        m_tag   = a1 ? req1_tag : req0_tag;
        m_err   = (op > 4'd6);
        m_rd    = m_err ? 32'h0 : ref_alu(op, x, y, z);
        m_due   = cyc + ((op == 4'd6) ? MAC_LAT : 1);
        acc_q.push_back(int'(a1));
        acc_cyc.push_back(cyc);
      end
    end
  end

  always @(negedge clk) begin
    chk("req0_ready", 32'(req0_ready), 32'(m_rdy(0)));
    chk("req1_ready", 32'(req1_ready), 32'(m_rdy(1)));
    chk("resp0_valid", 32'(resp0_valid), 32'(m_ev(0)));
    chk("resp1_valid", 32'(resp1_valid), 32'(m_ev(1)));
    if (req0_valid && req1_valid)
      chk("ready_exclusive", 32'(req0_ready & req1_ready), 32'd0);
    if (m_ev(0)) begin
      chk("resp0_rd", resp0_rd, m_rd);
      chk("resp0_tag", 32'(resp0_tag), 32'(m_tag));
      chk("resp0_err", 32'(resp0_err), 32'(m_err));
    end
    if (m_ev(1)) begin
      chk("resp1_rd", resp1_rd, m_rd);
      chk("resp1_tag", 32'(resp1_tag), 32'(m_tag));
      chk("resp1_err", 32'(resp1_err), 32'(m_err));
    end
    if (resp0_valid && resp0_ready)
      rsp_q.push_back('{port: 0, rd: resp0_rd, tag: resp0_tag, err: resp0_err, cyc: cyc + 1});
    if (resp1_valid && resp1_ready)
      rsp_q.push_back('{port: 1, rd: resp1_rd, tag: resp1_tag, err: resp1_err, cyc: cyc + 1});
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int n, input logic v, input logic [3:0] op,
                         input logic [31:0] a, b, c, input logic [3:0] tag);
    if (n == 0) begin
      req0_valid = v; req0_op = op; req0_rs1 = a; req0_rs2 = b; req0_rs3 = c; req0_tag = tag;
    end else begin
      req1_valid = v; req1_op = op; req1_rs1 = a; req1_rs2 = b; req1_rs3 = c; req1_tag = tag;
    end
  endtask

  task automatic do_reset();
    set_req(0, 1'b0, 4'd0, 0, 0, 0, 4'd0);
    set_req(1, 1'b0, 4'd0, 0, 0, 0, 4'd0);
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    acc_q.delete();
    acc_cyc.delete();
    rsp_q.delete();
  endtask

  task automatic wait_acc(input int count, input int limit);
    int k = 0;
    while (acc_q.size() < count && k < limit) begin
      tick(1);
      k++;
    end
    chk("accept_count", 32'(acc_q.size()), 32'(count));
  endtask

  initial begin
    int found;
    reset = 1'b1;
    x_req1_valid = 1'b0; x_req1_op = 4'd0;
    x_req1_rs1 = '0; x_req1_rs2 = '0; x_req1_rs3 = '0;
    set_req(0, 1'b0, 4'd0, 0, 0, 0, 4'd0);
    set_req(1, 1'b0, 4'd0, 0, 0, 0, 4'd0);
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    #2;
    do_reset();
    chk("rst_resp0_valid", 32'(resp0_valid), 32'd0);
    chk("rst_resp0_rd", resp0_rd, 32'd0);

    // single ADD
    set_req(0, 1'b1, 4'd0, 32'd5, 32'd7, 32'd0, 4'd3);
    wait_acc(1, 10);
    req0_valid = 1'b0;
    tick(6);
    chk("add_pulses", 32'(rsp_q.size()), 32'd1);
    if (rsp_q.size() == 1) begin
      chk("add_rd", rsp_q[0].rd, 32'd12);
      chk("add_tag", 32'(rsp_q[0].tag), 32'd3);
      chk("add_err", 32'(rsp_q[0].err), 32'd0);
      chk("add_port", 32'(rsp_q[0].port), 32'd0);
      chk("add_latency", 32'(rsp_q[0].cyc - acc_cyc[0]), 32'd2);
    end

    // tie: strict alternation starting with requester 0
    do_reset();
    set_req(0, 1'b1, 4'd1, 32'd10, 32'd3, 32'd0, 4'd1);
    set_req(1, 1'b1, 4'd3, 32'hF0, 32'h0F, 32'd0, 4'd2);
    wait_acc(4, 40);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick(8);
    chk("tie_resp_count", 32'(rsp_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < acc_q.size() && i < rsp_q.size(); i++) begin
      chk("tie_grant", 32'(acc_q[i]), 32'(i % 2));
      chk("tie_resp_port", 32'(rsp_q[i].port), 32'(i % 2));
      chk("tie_resp_rd", rsp_q[i].rd, (i % 2) ? 32'hFF : 32'd7);
    end

    // MAC with MAC_LAT=2: operands stable for both EXEC cycles
    do_reset();
    set_req(1, 1'b1, 4'd6, 32'd3, 32'd4, 32'd5, 4'd6);
    wait_acc(1, 10);
    req1_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("mac_alu_op", 32'(alu_opcode), 32'd6);
      chk("mac_alu_rs1", alu_rs1, 32'd3);
      chk("mac_alu_rs2", alu_rs2, 32'd4);
      chk("mac_alu_rs3", alu_rs3, 32'd5);
    end
    tick(6);
    chk("mac_resp_count", 32'(rsp_q.size()), 32'd1);
    if (rsp_q.size() == 1) begin
      chk("mac_rd", rsp_q[0].rd, 32'd17);
      chk("mac_port", 32'(rsp_q[0].port), 32'd1);
      chk("mac_latency", 32'(rsp_q[0].cyc - acc_cyc[0]), 32'd3);
    end

    // MAC with MAC_LAT=4 on the second instance
    x_req1_valid = 1'b1; x_req1_op = 4'd6;
    x_req1_rs1 = 32'd3; x_req1_rs2 = 32'd4; x_req1_rs3 = 32'd5;
    tick(1);
    x_req1_valid = 1'b0;
    found = 21;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (x_resp1_valid) begin
        found = k;
        break;
      end
    end
    chk("mac4_latency", 32'(found + 1), 32'd5);
    chk("mac4_rd", x_resp1_rd, 32'd17);
    tick(2);

    // back-pressure on response 0 with requester 1 waiting
    do_reset();
    resp0_ready = 1'b0;
    set_req(0, 1'b1, 4'd0, 32'd1, 32'd2, 32'd0, 4'd4);
    wait_acc(1, 10);
    req0_valid = 1'b0;
    set_req(1, 1'b1, 4'd2, 32'hF0F0, 32'hFF00, 32'd0, 4'd9);
    tick(1);
    repeat (5) begin
      chk("bp_valid", 32'(resp0_valid), 32'd1);
      chk("bp_rd", resp0_rd, 32'd3);
      chk("bp_tag", 32'(resp0_tag), 32'd4);
      tick(1);
    end
    resp0_ready = 1'b1;
    wait_acc(2, 10);
    req1_valid = 1'b0;
    tick(6);
    chk("bp_resp_count", 32'(rsp_q.size()), 32'd2);
    if (rsp_q.size() == 2 && acc_q.size() == 2) begin
      chk("bp_next_grant", 32'(acc_q[1]), 32'd1);
      chk("bp_gap", 32'(acc_cyc[1] - rsp_q[0].cyc), 32'd1);
      chk("bp_req1_rd", rsp_q[1].rd, 32'hF000);
    end

    // illegal opcode
    do_reset();
    set_req(0, 1'b1, 4'hF, 32'h1234, 32'h5678, 32'd0, 4'd2);
    wait_acc(1, 10);
    req0_valid = 1'b0;
    tick(6);
    chk("ill_resp_count", 32'(rsp_q.size()), 32'd1);
    if (rsp_q.size() == 1) begin
      chk("ill_rd", rsp_q[0].rd, 32'd0);
      chk("ill_err", 32'(rsp_q[0].err), 32'd1);
      chk("ill_tag", 32'(rsp_q[0].tag), 32'd2);
      chk("ill_latency", 32'(rsp_q[0].cyc - acc_cyc[0]), 32'd2);
    end

    // reset in the middle of a MAC
    do_reset();
    set_req(1, 1'b1, 4'd6, 32'd2, 32'd3, 32'd1, 4'd5);
    wait_acc(1, 10);
    req1_valid = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(6);
    chk("abort_no_resp", 32'(rsp_q.size()), 32'd0);
    chk("abort_ready0", 32'(req0_ready), 32'd1);
    chk("abort_ready1", 32'(req1_ready), 32'd1);
    set_req(0, 1'b1, 4'd0, 32'd1, 32'd1, 32'd0, 4'd1);
    set_req(1, 1'b1, 4'd0, 32'd2, 32'd2, 32'd0, 4'd2);
    wait_acc(2, 10);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (acc_q.size() >= 2)
      chk("abort_tie_winner", 32'(acc_q[1]), 32'd0);
    tick(6);
    chk("abort_tie_resp_rd", (rsp_q.size() > 0) ? rsp_q[0].rd : 32'hFFFF_FFFF, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
